ones_window_sum: RTL and testbench



---
 rtl/ones_window_sum_pkg.sv | 22 ++
 rtl/count_ring_buf.sv | 36 +++
 rtl/ones_window_sum.sv | 81 ++++++++
 tb/tb_ones_window_sum.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ones_window_sum_pkg.sv
// Shared types and helpers for the ones-count sliding-window summer.
package ones_window_sum_pkg;

    typedef enum logic {
        StFill   = 1'b0,
        StSteady = 1'b1
    } win_state_e;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/count_ring_buf.sv
// DEPTH-entry circular buffer of counts; the slot under the write pointer is the oldest entry.
module count_ring_buf
    import ones_window_sum_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    output logic [CNT_W-1:0] rd_data
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [CNT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointer wraps by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            mem    <= '{default: '0};
        end else if (clear) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/ones_window_sum.sv
// Sliding-window sum of the last DEPTH ones-counts with a registered density threshold flag.
module ones_window_sum
    import ones_window_sum_pkg::*;
#(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned THRESH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic [CNT_W-1:0]                in_count,
    output logic                            out_valid,
    output logic [CNT_W+clog2(DEPTH)-1:0]   win_sum,
    output logic                            win_full,
    output logic                            over_thresh
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned SUM_W = CNT_W + PTR_W;

    win_state_e       state;
    logic [PTR_W-1:0] fill_cnt;
    logic [CNT_W-1:0] oldest;
    logic [SUM_W-1:0] evict;
    logic [SUM_W-1:0] sum_d;
    logic             over_d;
    logic             accept;

    assign accept = in_valid & ~clear;

    count_ring_buf #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (in_count),
        .rd_data (oldest)
    );

    // During FILL the slot under the pointer holds no live sample, so nothing is evicted.
    always_comb begin
        evict  = (state == StSteady) ? SUM_W'(oldest) : '0;
        sum_d  = win_sum + SUM_W'(in_count) - evict;
        over_d = 32'(sum_d) >= THRESH;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= StFill;
            fill_cnt    <= '0;
            win_sum     <= '0;
            win_full    <= 1'b0;
            over_thresh <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                win_sum     <= sum_d;
                over_thresh <= over_d;
                case (state)
                    StFill: begin
                        if (fill_cnt == PTR_W'(DEPTH - 1)) begin
                            state    <= StSteady;
                            win_full <= 1'b1;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    default: state <= StSteady;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ones_window_sum.sv
// Self-checking bench: queue-based sliding-window model checked every cycle, plus literal checks.
module tb_ones_window_sum;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned THRESH = 16;
    localparam int unsigned SUM_W  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [CNT_W-1:0] in_count = '0;
    logic             out_valid;
    logic [SUM_W-1:0] win_sum;
    logic             win_full;
    logic             over_thresh;

    int n_cmp  = 0;
    int n_fail = 0;

    ones_window_sum #(
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_count    (in_count),
        .out_valid   (out_valid),
        .win_sum     (win_sum),
        .win_full    (win_full),
        .over_thresh (over_thresh)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the window is literally the last DEPTH accepted samples.
    int unsigned win_q[$];
    bit          live = 1'b0;
    int          exp_sum, exp_full, exp_over, exp_valid;

    always @(posedge clk) begin
        bit s_rst, s_clr, s_vld;
        int s_cnt;
        s_rst = rst; s_clr = clear; s_vld = in_valid; s_cnt = int'(in_count);
        if (s_rst || s_clr) begin
            if (s_rst) live = 1'b1;
            win_q.delete();
            exp_valid = 0;
            exp_sum   = 0;
            exp_full  = 0;
            exp_over  = 0;
        end else if (s_vld) begin
            win_q.push_back(s_cnt);
            if (win_q.size() > DEPTH) void'(win_q.pop_front());
            exp_sum = 0;
            foreach (win_q[i]) exp_sum += int'(win_q[i]);
            exp_full  = (win_q.size() == DEPTH) ? 1 : 0;
            exp_over  = (exp_sum >= int'(THRESH)) ? 1 : 0;
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        #1;
        if (live) begin
            check("model out_valid", int'(out_valid), exp_valid);
            check("model win_sum", int'(win_sum), exp_sum);
            check("model win_full", int'(win_full), exp_full);
            check("model over_thresh", int'(over_thresh), exp_over);
        end
    end

    // Drive one cycle's inputs on the falling edge, then land after the checker's sample point.
    task automatic step(input bit r, input bit c, input bit v, input int cnt);
        @(negedge clk);
        rst = r; clear = c; in_valid = v; in_count = CNT_W'(cnt);
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input int s, input int f, input int o, input int v);
        check({name, " sum"}, int'(win_sum), s);
        check({name, " full"}, int'(win_full), f);
        check({name, " over"}, int'(over_thresh), o);
        check({name, " valid"}, int'(out_valid), v);
    endtask

    initial begin
        int exp_s[4];
        int accepted;
        logic [7:0] b;

        // 1: reset then fill
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        lit("reset", 0, 0, 0, 0);
        exp_s = '{3, 8, 16, 18};
        step(0, 0, 1, 3);  lit("fill1", 3, 0, 0, 1);
        step(0, 0, 1, 5);  lit("fill2", 8, 0, 0, 1);
        step(0, 0, 1, 8);  lit("fill3", 16, 0, 1, 1);
        step(0, 0, 1, 2);  lit("fill4", exp_s[3], 1, 1, 1);

        // 2: steady-state eviction
        step(0, 0, 1, 1);  lit("evict3", 16, 1, 1, 1);
        step(0, 0, 1, 0);  lit("evict5", 11, 1, 0, 1);

        // 3: gaps, then wrap-around at full scale
        step(0, 1, 0, 0);  lit("clr", 0, 0, 0, 0);
        step(0, 0, 1, 4);  lit("gap a", 4, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 9);
            lit("idle", 4, 0, 0, 0);
        end
        step(0, 0, 1, 4);  lit("gap b", 8, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 15);
        lit("max", 60, 1, 1, 1);

        // 4: clear beats a simultaneous sample
        step(0, 1, 1, 7);  lit("clr+vld", 0, 0, 0, 0);
        step(0, 0, 1, 6);  lit("after clr", 6, 0, 0, 1);

        // 5: reset mid-fill
        step(1, 0, 0, 0);
        step(0, 0, 1, 2);
        step(0, 0, 1, 2);  lit("pre rst", 4, 0, 0, 1);
        step(1, 0, 1, 9);  lit("mid rst", 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, 1);
            lit("refill", i, (i == 4) ? 1 : 0, 0, 1);
        end

        // 6: random bytes through popcount; model checks every cycle
        accepted = 0;
        for (int i = 0; i < 2000 && accepted < 200; i++) begin
            bit v, c;
            b = 8'($urandom);
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 59) == 0);
            step(0, c, v, $countones(b));
            if (v && !c) accepted++;
        end
        check("random samples accepted", accepted, 200);

        step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
